btb_predictor: RTL and testbench

- Parametrised branch target buffer with 2-bit-style saturating direction counters for the fetch stage of the pipelined MIPS core.
- Replaces the fixed "predict not-taken, flush in ID" scheme.
- IF looks up the current PC combinationally and gets a predicted next PC. The resolving stage writes back the outcome and receives a mispredict flag and a recovery PC.
- Also keeps saturating performance counters.

---
 rtl/btb_predictor.sv | 155 +++++++++++++++
 tb/tb_btb_predictor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btb_predictor.sv
// Branch target buffer with saturating direction counters for the IF stage.
// The lookup is purely combinational on pc_i. The resolving stage writes the
// outcome back on the rising edge and gets a mispredict flag plus a recovery PC.
// Two saturating performance counters track lookup hits and mispredictions.
module btb_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              lookup_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] recovery_pc_o,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Counter encodings: MSB set means "predict taken".
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  // Per-entry state, gathered from the generate blocks for indexed reads.
  logic              valid_w  [ENTRIES];
  logic [TAG_W-1:0]  tag_w    [ENTRIES];
  logic [ADDR_W-1:0] target_w [ENTRIES];
  logic              jump_w   [ENTRIES];
  logic [CTR_W-1:0]  ctr_w    [ENTRIES];

  // Lookup side address split (pc bits [1:0] are word offset, ignored).
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [ADDR_W-1:0] lk_pc_plus4;

  assign lk_idx      = pc_i[IDX_W+1:2];
  assign lk_tag      = pc_i[ADDR_W-1:IDX_W+2];
  assign lk_pc_plus4 = pc_i + ADDR_W'(4);

  assign hit_o         = valid_w[lk_idx] && (tag_w[lk_idx] == lk_tag);
  assign pred_taken_o  = hit_o && (jump_w[lk_idx] || ctr_w[lk_idx][CTR_W-1]);
  assign pred_target_o = pred_taken_o ? target_w[lk_idx] : lk_pc_plus4;

  // Update side address split and tag check against current contents.
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CTR_W-1:0] upd_ctr_next;

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_w[upd_idx] && (tag_w[upd_idx] == upd_tag);

  // Saturating step of the direction counter of the entry being updated.
  always_comb begin
    upd_ctr_next = ctr_w[upd_idx];
    if (upd_taken_i) begin
      if (ctr_w[upd_idx] != CTR_MAX) upd_ctr_next = ctr_w[upd_idx] + CTR_W'(1);
    end else begin
      if (ctr_w[upd_idx] != '0) upd_ctr_next = ctr_w[upd_idx] - CTR_W'(1);
    end
  end

  // Mispredict detection and recovery PC are combinational on the update bus.
  assign mispredict_o  = upd_valid_i &&
                         ((upd_taken_i != upd_pred_taken_i) ||
                          (upd_taken_i && (upd_target_i != upd_pred_target_i)));
  assign recovery_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + ADDR_W'(4));

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [ADDR_W-1:0] target_reg;
      logic              jump_reg;
      logic [CTR_W-1:0]  ctr_reg;
      logic              sel;

      assign sel = upd_valid_i && (upd_idx == IDX_W'(gi));

      // Entry storage: clear beats update; tag hits train, taken misses allocate.
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          jump_reg   <= 1'b0;
          ctr_reg    <= CTR_WEAK_NT;
        end else if (clear_i) begin
          valid_reg <= 1'b0;
          ctr_reg   <= CTR_WEAK_NT;
        end else if (sel) begin
          if (upd_hit) begin
            ctr_reg  <= upd_ctr_next;
            jump_reg <= upd_is_jump_i;
            if (upd_taken_i) target_reg <= upd_target_i;
          end else if (upd_taken_i) begin
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= upd_target_i;
            jump_reg   <= upd_is_jump_i;
            ctr_reg    <= CTR_WEAK_T;
          end
        end
      end

      assign valid_w[gi]  = valid_reg;
      assign tag_w[gi]    = tag_reg;
      assign target_w[gi] = target_reg;
      assign jump_w[gi]   = jump_reg;
      assign ctr_w[gi]    = ctr_reg;
    end
  endgenerate

  logic [CNT_W-1:0] hit_cnt_reg;
  logic [CNT_W-1:0] mispred_cnt_reg;

  // Saturating performance counters; clear zeroes both.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_reg     <= '0;
      mispred_cnt_reg <= '0;
    end else if (clear_i) begin
      hit_cnt_reg     <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (lookup_valid_i && hit_o && (hit_cnt_reg != CNT_MAX))
        hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
      if (mispredict_o && (mispred_cnt_reg != CNT_MAX))
        mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
    end
  end

  assign hit_cnt_o     = hit_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: table of per-cycle vectors whose
// expected outputs are queued on drive and compared on the falling edge,
// plus a hand-written asynchronous-reset sequence.
module tb_btb_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_i;
  logic        lookup_valid_i;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_is_jump_i;
  logic        upd_pred_taken_i;
  logic [31:0] upd_pred_target_i;
  logic        mispredict_o;
  logic [31:0] recovery_pc_o;
  logic [15:0] hit_cnt_o;
  logic [15:0] mispred_cnt_o;

  int checks   = 0;
  int failures = 0;

  btb_predictor dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clear_i          (clear_i),
    .lookup_valid_i   (lookup_valid_i),
    .pc_i             (pc_i),
    .hit_o            (hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_is_jump_i    (upd_is_jump_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o     (mispredict_o),
    .recovery_pc_o    (recovery_pc_o),
    .hit_cnt_o        (hit_cnt_o),
    .mispred_cnt_o    (mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic        lv;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        uj;
    logic        upt;
    logic [31:0] uptgt;
    logic        clr;
    logic        e_hit;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_mp;
    logic [31:0] e_rpc;
    logic [15:0] e_hc;
    logic [15:0] e_mc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  vec_t sb_q [$];
  vec_t sb_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input int id, input logic lv, input logic [31:0] pc,
    input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
    input logic uj, input logic upt, input logic [31:0] uptgt, input logic clr,
    input logic e_hit, input logic e_pt, input logic [31:0] e_ptgt,
    input logic e_mp, input logic [31:0] e_rpc, input logic [15:0] e_hc,
    input logic [15:0] e_mc);
    vec_t v;
    v.id = id; v.lv = lv; v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut;
    v.utgt = utgt; v.uj = uj; v.upt = upt; v.uptgt = uptgt; v.clr = clr;
    v.e_hit = e_hit; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp;
    v.e_rpc = e_rpc; v.e_hc = e_hc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    lookup_valid_i    = v.lv;
    pc_i              = v.pc;
    upd_valid_i       = v.uv;
    upd_pc_i          = v.upc;
    upd_taken_i       = v.ut;
    upd_target_i      = v.utgt;
    upd_is_jump_i     = v.uj;
    upd_pred_taken_i  = v.upt;
    upd_pred_target_i = v.uptgt;
    clear_i           = v.clr;
  endtask

  // Scoreboard consumer: compare the oldest queued expectation mid-cycle.
  always @(negedge clk_i) begin
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      chk($sformatf("v%0d_hit", sb_e.id), 32'(hit_o), 32'(sb_e.e_hit));
      chk($sformatf("v%0d_pred_taken", sb_e.id), 32'(pred_taken_o), 32'(sb_e.e_pt));
      chk($sformatf("v%0d_pred_target", sb_e.id), pred_target_o, sb_e.e_ptgt);
      chk($sformatf("v%0d_mispredict", sb_e.id), 32'(mispredict_o), 32'(sb_e.e_mp));
      chk($sformatf("v%0d_recovery_pc", sb_e.id), recovery_pc_o, sb_e.e_rpc);
      chk($sformatf("v%0d_hit_cnt", sb_e.id), 32'(hit_cnt_o), 32'(sb_e.e_hc));
      chk($sformatf("v%0d_mispred_cnt", sb_e.id), 32'(mispred_cnt_o), 32'(sb_e.e_mc));
      $display("vec %0d pc=0x%0h hit=%0b taken=%0b tgt=0x%0h mp=%0b rpc=0x%0h hc=%0d mc=%0d",
               sb_e.id, pc_i, hit_o, pred_taken_o, pred_target_o, mispredict_o,
               recovery_pc_o, hit_cnt_o, mispred_cnt_o);
    end
  end

  initial begin
    //            id lv pc            uv upc          ut utgt      uj upt uptgt     clr  hit pt ptgt       mp rpc          hc mc
    vecs[0]  = mk(0, 1, 32'h40,       0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   0, 0, 32'h44,     0, 32'h4,       0, 0);
    vecs[1]  = mk(1, 0, 32'h100,      1, 32'h100,     1, 32'h200,  0, 0, 32'h0,     0,   0, 0, 32'h104,    1, 32'h200,     0, 0);
    vecs[2]  = mk(2, 1, 32'h100,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   1, 1, 32'h200,    0, 32'h4,       0, 1);
    vecs[3]  = mk(3, 0, 32'h100,      1, 32'h100,     0, 32'h0,    0, 1, 32'h200,   0,   1, 1, 32'h200,    1, 32'h104,     1, 1);
    vecs[4]  = mk(4, 0, 32'h100,      1, 32'h100,     0, 32'h0,    0, 0, 32'h0,     0,   1, 0, 32'h104,    0, 32'h104,     1, 2);
    vecs[5]  = mk(5, 0, 32'h100,      1, 32'h100,     0, 32'h0,    0, 0, 32'h0,     0,   1, 0, 32'h104,    0, 32'h104,     1, 2);
    vecs[6]  = mk(6, 0, 32'h100,      1, 32'h100,     1, 32'h200,  0, 0, 32'h104,   0,   1, 0, 32'h104,    1, 32'h200,     1, 2);
    vecs[7]  = mk(7, 0, 32'h100,      1, 32'h100,     1, 32'h200,  0, 0, 32'h104,   0,   1, 0, 32'h104,    1, 32'h200,     1, 3);
    vecs[8]  = mk(8, 1, 32'h100,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   1, 1, 32'h200,    0, 32'h4,       1, 4);
    vecs[9]  = mk(9, 0, 32'h100,      1, 32'h100,     1, 32'h200,  0, 1, 32'h200,   0,   1, 1, 32'h200,    0, 32'h200,     2, 4);
    vecs[10] = mk(10, 0, 32'h100,     1, 32'h100,     1, 32'h200,  0, 1, 32'h200,   0,   1, 1, 32'h200,    0, 32'h200,     2, 4);
    vecs[11] = mk(11, 0, 32'h100,     1, 32'h100,     0, 32'h0,    0, 1, 32'h200,   0,   1, 1, 32'h200,    1, 32'h104,     2, 4);
    vecs[12] = mk(12, 0, 32'h100,     1, 32'h140,     1, 32'h300,  0, 0, 32'h0,     0,   1, 1, 32'h200,    1, 32'h300,     2, 5);
    vecs[13] = mk(13, 1, 32'h100,     0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   0, 0, 32'h104,    0, 32'h4,       2, 6);
    vecs[14] = mk(14, 1, 32'h140,     0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   1, 1, 32'h300,    0, 32'h4,       2, 6);
    vecs[15] = mk(15, 1, 32'h08,      1, 32'h08,      1, 32'h80,   1, 0, 32'h0,     0,   0, 0, 32'h0c,     1, 32'h80,      3, 6);
    vecs[16] = mk(16, 1, 32'h08,      1, 32'h08,      0, 32'h0,    1, 1, 32'h80,    0,   1, 1, 32'h80,     1, 32'h0c,      3, 7);
    vecs[17] = mk(17, 0, 32'h08,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   1, 1, 32'h80,     0, 32'h4,       4, 8);
    vecs[18] = mk(18, 1, 32'h08,      1, 32'h20,      1, 32'h400,  0, 0, 32'h0,     1,   1, 1, 32'h80,     1, 32'h400,     4, 8);
    vecs[19] = mk(19, 1, 32'h20,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   0, 0, 32'h24,     0, 32'h4,       0, 0);
    vecs[20] = mk(20, 1, 32'h08,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   0, 0, 32'h0c,     0, 32'h4,       0, 0);
    vecs[21] = mk(21, 0, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 32'h0,  0, 0, 32'h0,     0,   0, 0, 32'h0,      0, 32'h0,       0, 0);
    vecs[22] = mk(22, 0, 32'h30,      1, 32'h30,      1, 32'h500,  0, 1, 32'h504,   0,   0, 0, 32'h34,     1, 32'h500,     0, 0);
    vecs[23] = mk(23, 1, 32'h30,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   1, 1, 32'h500,    0, 32'h4,       0, 1);
    vecs[24] = mk(24, 0, 32'h34,      0, 32'h0,       0, 32'h0,    0, 0, 32'h0,     0,   0, 0, 32'h38,     0, 32'h4,       1, 1);

    // Reset state, checked while reset is held.
    rst_i = 1'b1;
    drive(mk(-1, 1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
    #1 rst_i = 1'b0;
    #2;
    chk("rst_hit", 32'(hit_o), 32'h0);
    chk("rst_pred_taken", 32'(pred_taken_o), 32'h0);
    chk("rst_pred_target", pred_target_o, 32'h44);
    chk("rst_hit_cnt", 32'(hit_cnt_o), 32'h0);
    chk("rst_mispred_cnt", 32'(mispred_cnt_o), 32'h0);
    $display("reset pc=0x40 hit=%0b tgt=0x%0h", hit_o, pred_target_o);
    #9 rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i);
      #1;
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
    end

    // Let the scoreboard drain, bounded.
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(negedge clk_i);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end

    // Asynchronous reset in the middle of a cycle with an update pending.
    @(posedge clk_i);
    #1;
    drive(mk(-1, 0, 32'h30, 1, 32'h30, 1, 32'h600, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0));
    #2;
    chk("pre_arst_hit", 32'(hit_o), 32'h1);
    chk("pre_arst_target", pred_target_o, 32'h500);
    #1 rst_i = 1'b0;
    #1;
    chk("arst_hit", 32'(hit_o), 32'h0);
    chk("arst_pred_target", pred_target_o, 32'h34);
    chk("arst_hit_cnt", 32'(hit_cnt_o), 32'h0);
    chk("arst_mispred_cnt", 32'(mispred_cnt_o), 32'h0);
    $display("async reset pc=0x30 hit=%0b tgt=0x%0h hc=%0d mc=%0d",
             hit_o, pred_target_o, hit_cnt_o, mispred_cnt_o);
    @(posedge clk_i);
    #2;
    upd_valid_i = 1'b0;
    rst_i       = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("post_arst_hit", 32'(hit_o), 32'h0);
    chk("post_arst_target", pred_target_o, 32'h34);
    chk("post_arst_mispred_cnt", 32'(mispred_cnt_o), 32'h0);
    $display("after reset release pc=0x30 hit=%0b tgt=0x%0h", hit_o, pred_target_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
